// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt entry, ELR/ESR capture, ERET return and four-phase IRQ acknowledge.
// Define EXC_IRQ_SYNC_EN to pass ext_irq through a two-flop synchronizer before use.
module exc_ctrl #(
    parameter int          N      = 64,
    parameter logic [N-1:0] VECTOR = 64'h0000_0000_0000_00D8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ext_irq,
    output logic         ext_ack,
    output logic         irq_pending,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic [N-1:0] pc,
    output logic         exc_take,
    output logic [N-1:0] exc_vector,
    output logic [N-1:0] elr,
    output logic [3:0]   esr,
    output logic         in_handler,
    output logic         double_fault
);
    typedef enum logic {IDLE, HANDLER} state_t;
    state_t state, state_next;
    logic irq_eff;
`ifdef EXC_IRQ_SYNC_EN
    logic [1:0] irq_sync;
    always_ff @(posedge clk)
        irq_sync <= reset ? 2'b00 : {irq_sync[0], ext_irq};
    assign irq_eff = irq_sync[1];
`else
    assign irq_eff = ext_irq;
`endif
    assign exc_vector = VECTOR;
    always_comb begin
        state_next  = state;
        irq_pending = irq_eff && state == IDLE && !ext_ack;
        exc_take    = EStatus != 4'b0000 && state == IDLE;
        in_handler  = state == HANDLER;
        if (exc_take)
            state_next = HANDLER;
        else if (in_handler && ERet && EStatus != 4'b0010)
            state_next = IDLE;
    end
    // An IRQ entry returns past the interrupted instruction; a fault re-executes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            elr          <= '0;
            esr          <= 4'b0000;
            ext_ack      <= 1'b0;
            double_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (exc_take) begin
                esr <= EStatus;
                elr <= EStatus == 4'b0001 ? pc + N'(4) : pc;
            end
            ext_ack <= (exc_take && EStatus == 4'b0001) ? 1'b1 :
                       (ext_ack && !irq_eff) ? 1'b0 : ext_ack;
            if (in_handler && EStatus == 4'b0010)
                double_fault <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl; honours EXC_IRQ_SYNC_EN for input latency.
module tb_exc_ctrl;
`ifdef EXC_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic        clk = 0, reset = 1, ext_irq = 0, ERet = 0;
    logic [3:0]  EStatus = 0;
    logic [63:0] pc = 0;
    logic        ext_ack, irq_pending, exc_take, in_handler, double_fault;
    logic [63:0] exc_vector, elr;
    logic [3:0]  esr;
    int errors = 0, checks = 0;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .ext_irq(ext_irq), .ext_ack(ext_ack),
        .irq_pending(irq_pending), .EStatus(EStatus), .ERet(ERet), .pc(pc),
        .exc_take(exc_take), .exc_vector(exc_vector), .elr(elr), .esr(esr),
        .in_handler(in_handler), .double_fault(double_fault)
    );

    always #5 clk = ~clk;

    typedef enum int {S_PEND, S_TAKE, S_ELR, S_ESR, S_INH, S_ACK, S_DF, S_VEC} sig_e;
    typedef struct {sig_e s; logic [63:0] v; string tag;} exp_t;
    exp_t sb[$];

    function automatic logic [63:0] obs(sig_e s);
        case (s)
            S_PEND:  return {63'b0, irq_pending};
            S_TAKE:  return {63'b0, exc_take};
            S_ELR:   return elr;
            S_ESR:   return {60'b0, esr};
            S_INH:   return {63'b0, in_handler};
            S_ACK:   return {63'b0, ext_ack};
            S_DF:    return {63'b0, double_fault};
            default: return exc_vector;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_sig(input string tag, input sig_e s, input logic [63:0] v);
        exp_t e;
        e.s = s; e.v = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.s), e.v);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with an IRQ and its syndrome held.
        ext_irq = 1; EStatus = 4'b0001; pc = 64'h100;
        tick(2);
        expect_sig("rst_ack", S_ACK, 0);
        expect_sig("rst_elr", S_ELR, 0);
        expect_sig("rst_esr", S_ESR, 0);
        expect_sig("rst_inh", S_INH, 0);
        expect_sig("rst_df", S_DF, 0);
        expect_sig("vector", S_VEC, 64'hD8);
        drain();
        reset = 0; ext_irq = 0; EStatus = 0;
        expect_sig("idle_pend", S_PEND, 0);
        expect_sig("idle_take", S_TAKE, 0);
        drain();
        tick(LAT + 1);
        // External IRQ at pc 0x100.
        ext_irq = 1;
        tick(LAT);
        expect_sig("irq_pend", S_PEND, 1);
        drain();
        EStatus = 4'b0001;
        expect_sig("irq_take", S_TAKE, 1);
        drain();
        tick();
        EStatus = 0;
        expect_sig("irq_elr", S_ELR, 64'h104);
        expect_sig("irq_esr", S_ESR, 1);
        expect_sig("irq_inh", S_INH, 1);
        expect_sig("irq_ack", S_ACK, 1);
        expect_sig("h_pend", S_PEND, 0);
        drain();
        // ERET with the request still held: no second take.
        ERet = 1;
        tick();
        ERet = 0;
        expect_sig("eret_inh", S_INH, 0);
        expect_sig("eret_ack", S_ACK, 1);
        expect_sig("eret_pend", S_PEND, 0);
        drain();
        tick(2);
        expect_sig("hold_pend", S_PEND, 0);
        expect_sig("hold_inh", S_INH, 0);
        drain();
        ext_irq = 0;
        tick(LAT);
        expect_sig("rel_ack_hi", S_ACK, 1);
        drain();
        tick();
        expect_sig("rel_ack_lo", S_ACK, 0);
        expect_sig("rel_pend", S_PEND, 0);
        drain();
        // Invalid opcode, then double fault inside handler.
        pc = 64'h200; EStatus = 4'b0010;
        expect_sig("inv_take", S_TAKE, 1);
        drain();
        tick();
        expect_sig("inv_elr", S_ELR, 64'h200);
        expect_sig("inv_esr", S_ESR, 2);
        expect_sig("inv_inh", S_INH, 1);
        expect_sig("inv_ack", S_ACK, 0);
        pc = 64'h300;
        expect_sig("dbl_take", S_TAKE, 0);
        drain();
        tick();
        EStatus = 0;
        expect_sig("dbl_df", S_DF, 1);
        expect_sig("dbl_elr", S_ELR, 64'h200);
        expect_sig("dbl_esr", S_ESR, 2);
        expect_sig("dbl_inh", S_INH, 1);
        drain();
        ERet = 1;
        tick();
        expect_sig("dret_inh", S_INH, 0);
        expect_sig("dret_df", S_DF, 1);
        drain();
        // ERET in IDLE is ignored.
        tick();
        ERet = 0;
        expect_sig("idle_eret_inh", S_INH, 0);
        expect_sig("idle_eret_elr", S_ELR, 64'h200);
        drain();
        // pc+4 wraps.
        ext_irq = 1;
        tick(LAT);
        pc = 64'hFFFF_FFFF_FFFF_FFFC; EStatus = 4'b0001;
        tick();
        EStatus = 0;
        expect_sig("wrap_elr", S_ELR, 0);
        expect_sig("wrap_esr", S_ESR, 1);
        expect_sig("wrap_ack", S_ACK, 1);
        drain();
        // Request release coinciding with ERET.
        ext_irq = 0;
        tick(LAT);
        ERet = 1;
        tick();
        ERet = 0;
        expect_sig("sim_ack", S_ACK, 0);
        expect_sig("sim_inh", S_INH, 0);
        drain();
        // Reset mid-handler.
        pc = 64'h300; EStatus = 4'b0010;
        tick();
        tick();
        EStatus = 0;
        expect_sig("pre_elr", S_ELR, 64'h300);
        expect_sig("pre_df", S_DF, 1);
        drain();
        reset = 1;
        tick();
        reset = 0;
        expect_sig("mid_rst_inh", S_INH, 0);
        expect_sig("mid_rst_elr", S_ELR, 0);
        expect_sig("mid_rst_esr", S_ESR, 0);
        expect_sig("mid_rst_df", S_DF, 0);
        expect_sig("mid_rst_ack", S_ACK, 0);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt controller for the single-cycle LEGv8 core. Sits between the external interrupt source, the main decoder and the PC logic. It gates the decoder's IRQ input and latches the return address and syndrome on exception entry. It tracks handler state until ERET and runs a four-phase request/acknowledge handshake with the interrupting device.

## Interface
Parameters:
- `N` — 64 — PC/ELR width.
- `VECTOR` — 64'h0000_0000_0000_00D8 — exception handler address.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — reset, synchronous, active-high.
- `ext_irq` in 1 — level interrupt request from device.
- `ext_ack` out 1 — acknowledge to device (four-phase).
- `irq_pending` out 1 — drives decoder ExtIRQ input.
- `EStatus` in 4 — decoder syndrome: 0000 none, 0001 ext IRQ, 0010 invalid opcode.
- `ERet` in 1 — decoder ERET strobe.
- `pc` in N — PC of instruction in execution.
- `exc_take` out 1 — PC mux select: next PC = `exc_vector`.
- `exc_vector` out N — constant `VECTOR`.
- `elr` out N — exception link register.
- `esr` out 4 — exception syndrome register.
- `in_handler` out 1 — high while in HANDLER.
- `double_fault` out 1 — sticky; invalid opcode seen inside handler.

## Operation
- FSM states: IDLE, HANDLER. Reset → IDLE.
- `irq_eff` = `ext_irq` (see Configuration).
- Combinational outputs:
  - `irq_pending = irq_eff & (state==IDLE) & ~ext_ack`
  - `exc_take = (EStatus!=0) & (state==IDLE)`
  - `in_handler = (state==HANDLER)`
- IDLE, `exc_take`=1, at clock edge:
  - state→HANDLER; `esr`←`EStatus`.
  - `elr`←`pc+4` if EStatus=0001, because the interrupted instruction completes.
  - `elr`←`pc` if EStatus=0010, because the faulting instruction is re-executed after return.
  - If EStatus=0001, `ext_ack`←1.
- HANDLER:
  - `irq_pending`=0 and `exc_take`=0.
  - ERet=1 → IDLE at next edge; `elr`/`esr` keep their values.
  - EStatus=0010 → `double_fault`←1, remain in HANDLER, `elr`/`esr` unchanged.
- IDLE with ERet=1 and EStatus=0 → ignored, no state change.
- Handshake:
  - `ext_ack` clears at the first edge where `ext_ack`=1 and `irq_eff`=0.
  - While `ext_ack`=1, no new IRQ is offered, so an un-released request is never taken twice.
- Arithmetic: `pc+4` is N-bit and wraps modulo 2^N.
- `double_fault` clears only on reset.

## Timing
- Reset values: state IDLE; `elr`=0, `esr`=0, `ext_ack`=0, `double_fault`=0, sync flops=0.
- Resulting combinational outputs at reset: `irq_pending`=0 when `ext_irq`=0; `exc_take`=0 when `EStatus`=0; `in_handler`=0.
- Reset mid-handler or mid-handshake aborts everything to the reset values at that edge.
- Latency from `irq_eff` high to `irq_pending` is 0 cycles. `exc_take` asserts in the same cycle, via the decoder.
- `elr`/`esr`/`in_handler` update at the edge ending the take cycle. `ext_ack` rises at that same edge.
- ERET: `in_handler` falls one edge after the ERet cycle. An IRQ can be taken in the first IDLE cycle, provided `ext_ack`=0.
- Simultaneous events:
  - IRQ and invalid opcode in IDLE: the decoder reports 0001, so the IRQ wins and `elr`=`pc+4`.
  - `irq_eff` falling in the same cycle as ERet: `ext_ack` clears; the state change to IDLE also happens.

## Configuration
- `EXC_IRQ_SYNC_EN`:
  - Defined: `ext_irq` passes through a two-flop synchronizer before use as `irq_eff`. This adds 2 cycles of latency on both assert and deassert.
  - Undefined: `irq_eff`=`ext_irq` directly; the input is assumed synchronous to `clk`.

## Test plan
- Reset with `ext_irq`=1 and EStatus=0001 held → `ext_ack`=0, `elr`=0, `esr`=0, state IDLE.
- IDLE, `pc`=0x100, `ext_irq`=1, EStatus=0001 → `exc_take`=1 that cycle; next cycle `elr`=0x104, `esr`=0001, `in_handler`=1, `ext_ack`=1. Then drop `ext_irq` → `ext_ack`=0 one edge later (three edges later with `EXC_IRQ_SYNC_EN`).
- Keep `ext_irq`=1 through handler and ERET → after return `irq_pending`=0 until `ext_irq` drops and `ext_ack` clears; no second take.
- IDLE, `pc`=0x200, EStatus=0010 → `elr`=0x200, `esr`=0010. In HANDLER, EStatus=0010 → `double_fault`=1 and `elr`/`esr` unchanged. ERet → IDLE; `double_fault` stays 1.
- `pc`=0xFFFF_FFFF_FFFF_FFFC, IRQ → `elr`=0. Reset asserted in HANDLER → IDLE and all registers 0 at that edge.
